z_result_buffer: RTL and testbench

- Two-beat result buffer between the ALU and the 32-bit datapath bus.
- Accepts one ALU result per handshake: z_low, z_high and a flag saying whether z_high is meaningful. Multiply and divide use z_high; shifts, rotates and logic ops do not.
- Stores the result in a small FIFO of Z-register entries.
- Replays each entry onto the bus as a low beat, followed by a high beat only when the entry carries one. The low/high pair replaces the plain Z register ahead of the bus multiplexer.

---
 rtl/z_result_buffer_if.sv | 29 ++
 rtl/z_result_buffer.sv | 111 +++++++++++
 tb/tb_z_result_buffer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/z_result_buffer_if.sv
// z_result_buffer_if: ALU-side push handshake and bus-side beat handshake
// of the Z result buffer, plus its entry count.
interface z_result_buffer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_low;
    logic [WIDTH-1:0] in_high;
    logic             in_has_hi;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_is_hi;
    logic             out_last;
    logic [1:0]       count;

    // ALU producer and bus consumer side
    modport master (
        output in_valid, in_low, in_high, in_has_hi, out_ready,
        input  in_ready, out_valid, out_data, out_is_hi, out_last, count
    );

    // Buffer side
    modport slave (
        input  in_valid, in_low, in_high, in_has_hi, out_ready,
        output in_ready, out_valid, out_data, out_is_hi, out_last, count
    );
endinterface

// File: rtl/z_result_buffer.sv
// z_result_buffer: small FIFO of Z-register entries {low, high, has_hi}
// replayed onto the datapath bus as a low beat plus an optional high beat.
// Z_PAIR_BUFFER_EN defined: two entries deep; undefined: one entry deep.
module z_result_buffer #(
    parameter int unsigned WIDTH = 32
) (
    input logic             clk,
    input logic             clr,
    z_result_buffer_if.slave bus
);
`ifdef Z_PAIR_BUFFER_EN
    localparam int unsigned DEPTH = 2;
`else
    localparam int unsigned DEPTH = 1;
`endif
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [WIDTH-1:0] low;
        logic [WIDTH-1:0] high;
        logic             has_hi;
    } entry_t;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_LO,
        S_HI
    } state_t;

    state_t           state;
    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr_n;
    logic [PTR_W-1:0] wr_ptr_n;
    logic [1:0]       count_n;
    logic [1:0]       remain;
    logic             push;
    logic             pop;
    logic             beat;
    entry_t           in_entry;
    entry_t           head_n;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : PTR_W'(32'(p) + 32'd1);
    endfunction

    // Handshake decode and the head entry as seen after this edge
    always_comb begin
        beat      = bus.out_valid & bus.out_ready;
        pop       = beat & bus.out_last;
        push      = bus.in_valid & bus.in_ready;
        count_n   = bus.count + 2'(push) - 2'(pop);
        remain    = bus.count - 2'(pop);
        rd_ptr_n  = pop  ? ptr_inc(rd_ptr) : rd_ptr;
        wr_ptr_n  = push ? ptr_inc(wr_ptr) : wr_ptr;
        in_entry.low    = bus.in_low;
        in_entry.high   = bus.in_high;
        in_entry.has_hi = bus.in_has_hi;
        // With nothing left behind the retiring head, the new head is the
        // entry being written on this same edge (no EMPTY bubble).
        head_n    = (remain == 2'd0) ? in_entry : mem[rd_ptr_n];
    end

    // Entry storage written at the tail
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_entry;
        end
    end

    // Output FSM, pointers, count and registered handshake outputs
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state         <= S_EMPTY;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            bus.count     <= 2'd0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_is_hi <= 1'b0;
            bus.out_last  <= 1'b0;
        end else begin
            rd_ptr       <= rd_ptr_n;
            wr_ptr       <= wr_ptr_n;
            bus.count    <= count_n;
            bus.in_ready <= (32'(count_n) < DEPTH);
            if (state == S_LO && beat && !bus.out_last) begin
                state         <= S_HI;
                bus.out_data  <= mem[rd_ptr].high;
                bus.out_is_hi <= 1'b1;
                bus.out_last  <= 1'b1;
            end else if (state == S_EMPTY || pop) begin
                if (count_n != 2'd0) begin
                    state         <= S_LO;
                    bus.out_valid <= 1'b1;
                    bus.out_data  <= head_n.low;
                    bus.out_is_hi <= 1'b0;
                    bus.out_last  <= ~head_n.has_hi;
                end else begin
                    state         <= S_EMPTY;
                    bus.out_valid <= 1'b0;
                    bus.out_data  <= '0;
                    bus.out_is_hi <= 1'b0;
                    bus.out_last  <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_z_result_buffer.sv
// tb_z_result_buffer: queue-based reference model of the Z result buffer,
// directed scenarios with literal expectations, then random traffic.
module tb_z_result_buffer;
    localparam int unsigned W = 32;
`ifdef Z_PAIR_BUFFER_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    typedef struct {
        logic [31:0] low;
        logic [31:0] high;
        logic        has_hi;
    } ent_t;

    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    z_result_buffer_if #(.WIDTH(W)) bus ();

    z_result_buffer #(.WIDTH(W)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    ent_t        q[$];
    bit          phase = 1'b0;
    int          n_asrt = 0;
    int          n_fail = 0;
    int          n_push = 0;
    int          cyc = 0;
    int          push_cyc[$];
    int          max_cnt = 0;
    logic [31:0] shifted;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_asrt++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of entries plus "high beat pending" flag
    always @(posedge clk or posedge clr) begin
        bit   m_push;
        bit   m_last;
        ent_t e;
        if (clr) begin
            q.delete();
            phase = 1'b0;
        end else begin
            cyc++;
            m_push = bus.in_valid && (q.size() < DEPTH);
            if (q.size() > 0 && bus.out_ready) begin
                m_last = phase || !q[0].has_hi;
                if (m_last) begin
                    void'(q.pop_front());
                    phase = 1'b0;
                end else begin
                    phase = 1'b1;
                end
            end
            if (m_push) begin
                e.low    = bus.in_low;
                e.high   = bus.in_high;
                e.has_hi = bus.in_has_hi;
                q.push_back(e);
                n_push++;
                push_cyc.push_back(cyc);
            end
        end
        #1;
        if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
        chk("m_out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
        chk("m_count", 32'(bus.count), 32'(q.size()));
        chk("m_in_ready", 32'(bus.in_ready), 32'(q.size() < DEPTH));
        if (q.size() > 0) begin
            chk("m_out_data", bus.out_data, phase ? q[0].high : q[0].low);
            chk("m_out_is_hi", 32'(bus.out_is_hi), 32'(phase));
            chk("m_out_last", 32'(bus.out_last), 32'(phase || !q[0].has_hi));
        end else begin
            chk("m_idle_data", bus.out_data, 32'd0);
            chk("m_idle_is_hi", 32'(bus.out_is_hi), 32'd0);
            chk("m_idle_last", 32'(bus.out_last), 32'd0);
        end
    end

    // Present a result and hold it until the model sees it accepted
    task automatic push(input logic [31:0] lo, input logic [31:0] hi, input logic hh);
        int start;
        start         = n_push;
        bus.in_valid  = 1'b1;
        bus.in_low    = lo;
        bus.in_high   = hi;
        bus.in_has_hi = hh;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (n_push != start) break;
        end
        chk("push_accepted", 32'(n_push - start), 32'd1);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        bus.in_valid  = 1'b0;
        bus.in_low    = '0;
        bus.in_high   = '0;
        bus.in_has_hi = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_data", bus.out_data, 32'd0);
        clr = 1'b0;
        @(negedge clk);

        // Low-only result: one beat, then idle
        bus.out_ready = 1'b1;
        shifted = 32'h0001_5555;
        push(shifted >> 7, 32'hDEAD_BEEF, 1'b0);
        chk("lo_data", bus.out_data, 32'h0000_02AA);
        chk("lo_is_hi", 32'(bus.out_is_hi), 32'd0);
        chk("lo_last", 32'(bus.out_last), 32'd1);
        @(negedge clk);
        chk("lo_then_empty", 32'(bus.out_valid), 32'd0);

        // Two-beat result with a stalled consumer
        bus.out_ready = 1'b0;
        push(32'h89AB_CDEF, 32'h0123_4567, 1'b1);
        chk("tb_lo_data", bus.out_data, 32'h89AB_CDEF);
        chk("tb_lo_last", 32'(bus.out_last), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("tb_stall_data", bus.out_data, 32'h89AB_CDEF);
            chk("tb_stall_valid", 32'(bus.out_valid), 32'd1);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("tb_hi_data", bus.out_data, 32'h0123_4567);
        chk("tb_hi_is_hi", 32'(bus.out_is_hi), 32'd1);
        chk("tb_hi_last", 32'(bus.out_last), 32'd1);
        @(negedge clk);
        chk("tb_then_empty", 32'(bus.out_valid), 32'd0);

        // Reset during the high beat discards the entry
        push(32'h0000_0005, 32'h0000_0001, 1'b1);
        @(negedge clk);
        chk("mid_hi_beat", 32'(bus.out_is_hi), 32'd1);
        chk("mid_hi_data", bus.out_data, 32'h0000_0001);
        clr = 1'b1;
        #1;
        chk("mid_clr_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_clr_count", 32'(bus.count), 32'd0);
        chk("mid_clr_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        clr = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("mid_no_hi_valid", 32'(bus.out_valid), 32'd0);
            chk("mid_no_hi_is_hi", 32'(bus.out_is_hi), 32'd0);
        end

`ifdef Z_PAIR_BUFFER_EN
        // Back-to-back deposits while the consumer stalls
        bus.out_ready = 1'b0;
        push(32'h0001_FFFF, 32'h0, 1'b0);
        push(32'h0001_5400, 32'h0000_0000, 1'b1);
        chk("b2b_count", 32'(bus.count), 32'd2);
        chk("b2b_in_ready", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        chk("b2b_beat0", bus.out_data, 32'h0001_FFFF);
        @(negedge clk);
        chk("b2b_beat1", bus.out_data, 32'h0001_5400);
        @(negedge clk);
        chk("b2b_beat2", bus.out_data, 32'h0000_0000);
        chk("b2b_beat2_hi", 32'(bus.out_is_hi), 32'd1);
        @(negedge clk);
        chk("b2b_empty", 32'(bus.out_valid), 32'd0);
`endif

        // Full buffer: final beat taken while a new result waits
        bus.out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) push(32'h100 + 32'(i), 32'h0, 1'b0);
        chk("full_count", 32'(bus.count), 32'(DEPTH));
        bus.in_valid  = 1'b1;
        bus.in_low    = 32'h0000_0ABC;
        bus.in_has_hi = 1'b0;
        bus.out_ready = 1'b1;
        start = n_push;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("full_no_accept", 32'(n_push - start), 32'd0);
        chk("full_after_pop", 32'(bus.count), 32'(DEPTH - 1));
        @(negedge clk);
        chk("full_accept_next", 32'(n_push - start), 32'd1);
        chk("full_count_end", 32'(bus.count), 32'(DEPTH));
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (DEPTH + 3) @(negedge clk);

        // Two low-only results back-to-back with the consumer ready
        push_cyc.delete();
        max_cnt = 0;
        push(32'h0000_1111, 32'h0, 1'b0);
        push(32'h0000_2222, 32'h0, 1'b0);
        chk("seq_gap", 32'(push_cyc[1] - push_cyc[0]), (DEPTH == 1) ? 32'd2 : 32'd1);
        repeat (3) @(negedge clk);
        chk("seq_max_count", 32'(max_cnt <= DEPTH), 32'd1);

        // Random traffic with occasional resets
        for (int i = 0; i < 800; i++) begin
            clr           = ($urandom_range(0, 99) == 0);
            bus.in_valid  = ($urandom_range(0, 2) != 0);
            bus.in_low    = $urandom;
            bus.in_high   = $urandom;
            bus.in_has_hi = $urandom_range(0, 1) != 0;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end
        clr           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (6) @(negedge clk);
        chk("final_drained", 32'(bus.out_valid), 32'd0);
        chk("final_max_count", 32'(max_cnt <= DEPTH), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
